keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Drives the column lines of the 4x4 Pmod keypad and samples its row lines.
- Debounces the scanned matrix and delivers one 4-bit key code per distinct press over a valid/ack holding register.
- Feeds player-B control logic in place of the passive row-only decode.
- Single clock domain on the 100 MHz board clock.

Parameters:
- SCAN_DIV, 100000: clk cycles each column is driven low (1 ms at 100 MHz). Must be >= 4.
- DEBOUNCE_SCANS, 4: consecutive identical full-matrix frames needed to accept a new stable state. Range 1..15.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset. Asynchronous, active-low: rst=0 resets the block.
- row  input  4  keypad rows. Active-low, pulled up externally, asynchronous to clk.
- col  output 4  keypad column drive. Exactly one bit is low at any time.
- key_code  output 4  code of the held-pending key.
- key_valid  output 1  key_code holds an unconsumed press.
- key_ack  input 1  consumer acknowledge. Sampled only while key_valid=1.
- key_held  output 1  a single debounced key is currently down.
- key_overrun  output 1  sticky flag: a press was dropped while key_valid=1.

Behaviour:
- Reset values (async, rst=0):
  - col=4'b1110.
  - Column index 0; slot counter 0.
  - Synchronizer flops = 4'b1111.
  - key_code=0, key_valid=0, key_held=0, key_overrun=0.
  - Stable state = NONE; candidate = NONE; debounce count 0.
  - Reset asserted mid-scan or mid-debounce abandons all partial work; no event is emitted after release for keys held across reset until a full debounce completes.
- Synchronization: row passes through a 2-flop synchronizer before any use.
- Scan:
  - Column c (0..3) is driven low for SCAN_DIV cycles: col = ~(1<<c).
  - The synchronized row is sampled on the last cycle of the slot (slot counter = SCAN_DIV-1).
  - c then advances, wrapping 3->0.
  - One frame = 4*SCAN_DIV cycles.
- Key map (row r, col c -> code):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Frame evaluation (cycle after the col-3 sample):
  - Zero pressed bits -> frame value NONE.
  - Exactly one pressed bit -> frame value = that code.
  - Two or more pressed bits -> frame is INVALID. Candidate and count are left unchanged; the frame neither extends nor breaks a streak.
- Debounce:
  - If the frame value equals the candidate, count increments, saturating at DEBOUNCE_SCANS.
  - Otherwise candidate = frame value and count = 1.
  - When count reaches DEBOUNCE_SCANS and candidate != stable, stable <= candidate.
- Events:
  - A stable transition to a code (from NONE or from a different code) is a press event.
  - A transition to NONE is a release and produces no event.
  - key_held = (stable != NONE), updated in the same cycle as stable.
- Holding register:
  - Press event with key_valid=0: next cycle key_code <= code, key_valid <= 1.
  - key_ack=1 with key_valid=1: key_valid <= 0 and key_overrun <= 0. key_code keeps its value.
  - Press event with key_valid=1 and key_ack=0: the event is dropped and key_overrun <= 1. key_code is unchanged.
  - Press event and key_ack in the same cycle: key_code <= new code, key_valid stays 1, key_overrun <= 0.
  - key_ack while key_valid=0 is ignored.
- Latency: key_valid rises 1 cycle after the frame evaluation that completes the debounce, i.e. 2 cycles after the final col-3 sample.

Test Plan:
- Settings: SCAN_DIV=4, DEBOUNCE_SCANS=2 (frame = 16 cycles).
- Reset/scan: hold rst=0, then release.
  - During reset: col=1110.
  - After release: col steps 1110,1101,1011,0111, 4 cycles each, then wraps.
  - All outputs stay 0 with row=1111.
- Single press: model pulls row[1] low whenever col[2]=0 (key 6) for 3 frames.
  - key_valid rises 2 cycles after the 2nd frame's col-3 sample, with key_code=4'h6 and key_held=1.
  - Assert key_ack one cycle -> key_valid=0.
  - Release the key -> key_held=0 after 2 NONE frames; no new key_valid.
- Bounce: key 5 toggles on/off on alternate frames for 6 frames -> key_valid never asserts, key_held stays 0.
- Overrun: press key A, no ack, release, then press key 3.
  - key_code stays 4'hA.
  - key_overrun=1.
  - ack -> key_valid=0, key_overrun=0.
- Same-cycle ack: key_valid=1 with code 1; key_ack asserted in the cycle key 2's press event fires.
  - key_code=4'h2, key_valid stays 1, key_overrun=0.
- Multi-key/reset: hold keys 1 and 9 together -> frames INVALID, no event.
  - Pull rst low mid-frame -> outputs clear immediately and col=1110.
  - After release, holding key 9 alone yields key_valid with code 9 only after 2 full frames.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// Signal bundle between the 4x4 keypad scanner and its pins/consumer.
// Handshake: key_valid holds key_code until the consumer raises key_ack for one cycle.
interface keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       key_held;
  logic       key_overrun;

  modport master (
    input  row, key_ack,
    output col, key_code, key_valid, key_held, key_overrun
  );

  modport slave (
    output row, key_ack,
    input  col, key_code, key_valid, key_held, key_overrun
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with full-matrix debounce and a valid/ack key holding register.
// Handshake: key_valid stays high with key_code stable until key_ack=1 is seen while key_valid=1.
module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             rst,
  keypad_scanner_if.master kp
);
  localparam int              SLOT_W    = $clog2(SCAN_DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [3:0]      DB        = 4'(DEBOUNCE_SCANS);
  // Bit 4 set marks the NONE frame/state; otherwise bits 3:0 carry a key code.
  localparam logic [4:0]      NONE      = 5'h10;

  logic [3:0]        row_meta_q, row_sync_q;
  logic [SLOT_W-1:0] slot_q;
  logic [1:0]        col_idx_q;
  logic [3:0]        col_q;
  logic [15:0]       pressed_q;
  logic              eval_q;
  logic [4:0]        cand_q, stable_q;
  logic [3:0]        cnt_q;
  logic              press_q;
  logic [3:0]        press_code_q;
  logic [3:0]        key_code_q;
  logic              key_valid_q, key_overrun_q;

  logic [4:0] n_pressed, frame_val, cand_d;
  logic [3:0] hit_code, cnt_d;
  logic       frame_invalid, slot_end;

  function automatic logic [3:0] code_of(input logic [3:0] idx);
    case (idx)
      4'd0:  code_of = 4'h1;  4'd1:  code_of = 4'h2;  4'd2:  code_of = 4'h3;  4'd3:  code_of = 4'hA;
      4'd4:  code_of = 4'h4;  4'd5:  code_of = 4'h5;  4'd6:  code_of = 4'h6;  4'd7:  code_of = 4'hB;
      4'd8:  code_of = 4'h7;  4'd9:  code_of = 4'h8;  4'd10: code_of = 4'h9;  4'd11: code_of = 4'hC;
      4'd12: code_of = 4'h0;  4'd13: code_of = 4'hF;  4'd14: code_of = 4'hE;  default: code_of = 4'hD;
    endcase
  endfunction

  assign slot_end = (slot_q == SLOT_LAST);

  // pressed_q index is {row, col}; a frame with more than one bit set is ignored.
  always_comb begin
    n_pressed = '0;
    hit_code  = '0;
    for (int i = 0; i < 16; i++) begin
      if (pressed_q[i]) begin
        n_pressed = n_pressed + 5'd1;
        hit_code  = code_of(4'(i));
      end
    end
    frame_invalid = (n_pressed > 5'd1);
    frame_val     = (n_pressed == 5'd0) ? NONE : {1'b0, hit_code};
    if (frame_val == cand_q) begin
      cand_d = cand_q;
      cnt_d  = (cnt_q >= DB) ? cnt_q : cnt_q + 4'd1;
    end else begin
      cand_d = frame_val;
      cnt_d  = 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta_q    <= 4'hF;
      row_sync_q    <= 4'hF;
      slot_q        <= '0;
      col_idx_q     <= 2'd0;
      col_q         <= 4'b1110;
      pressed_q     <= '0;
      eval_q        <= 1'b0;
      cand_q        <= NONE;
      stable_q      <= NONE;
      cnt_q         <= 4'd0;
      press_q       <= 1'b0;
      press_code_q  <= 4'd0;
      key_code_q    <= 4'd0;
      key_valid_q   <= 1'b0;
      key_overrun_q <= 1'b0;
    end else begin
      row_meta_q <= kp.row;
      row_sync_q <= row_meta_q;
      eval_q     <= 1'b0;
      press_q    <= 1'b0;

      if (slot_end) begin
        slot_q    <= '0;
        col_idx_q <= col_idx_q + 2'd1;
        col_q     <= {col_q[2:0], col_q[3]};
        for (int r = 0; r < 4; r++) begin
          pressed_q[{2'(r), col_idx_q}] <= ~row_sync_q[r];
        end
        eval_q <= (col_idx_q == 2'd3);
      end else begin
        slot_q <= slot_q + 1'b1;
      end

      if (eval_q && !frame_invalid) begin
        cand_q <= cand_d;
        cnt_q  <= cnt_d;
        if (cnt_d == DB && cand_d != stable_q) begin
          stable_q     <= cand_d;
          press_q      <= ~cand_d[4];
          press_code_q <= cand_d[3:0];
        end
      end

      // A press arriving together with the ack replaces the pending code.
      if (press_q) begin
        if (!key_valid_q) begin
          key_code_q  <= press_code_q;
          key_valid_q <= 1'b1;
        end else if (kp.key_ack) begin
          key_code_q    <= press_code_q;
          key_overrun_q <= 1'b0;
        end else begin
          key_overrun_q <= 1'b1;
        end
      end else if (key_valid_q && kp.key_ack) begin
        key_valid_q   <= 1'b0;
        key_overrun_q <= 1'b0;
      end
    end
  end

  assign kp.col         = col_q;
  assign kp.key_code    = key_code_q;
  assign kp.key_valid   = key_valid_q;
  assign kp.key_held    = ~stable_q[4];
  assign kp.key_overrun = key_overrun_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2 (16-cycle frames).
// A keypad model ties rows to driven columns; expected key codes flow through exp_q.
module tb_keypad_scanner;
  localparam int SD = 4;
  localparam int DBS = 2;
  localparam int FR = 4 * SD;
  localparam int K1 = 0, K2 = 1, K3 = 2, KA = 3, K5 = 5, K6 = 6, K9 = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  keypad_scanner_if kif();
  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DBS)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kif)
  );

  logic [15:0] keys_down = '0;
  logic [3:0]  row_v;
  int          cyc;
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  exp_q[$];

  // Key at {r,c} pulls row r low only while column c is driven low.
  always_comb begin
    row_v = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys_down[r*4+c] && !kif.col[c]) row_v[r] = 1'b0;
  end
  assign kif.row = row_v;

  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;

  task automatic goto_cyc(input int t);
    int guard = 0;
    while (cyc < t && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (cyc !== t) begin
      errors++;
      $display("FAIL goto_cyc: at cycle %0d, wanted %0d", cyc, t);
    end
  endtask

  task automatic frame_start(output int base);
    @(negedge clk);
    for (int g = 0; g < FR && (cyc % FR) != 0; g++) @(negedge clk);
    base = cyc;
  endtask

  task automatic test_reset();
    logic [3:0] one = 4'b0001;
    logic [3:0] exp_col;
    rst = 1'b0;
    keys_down = '0;
    kif.key_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (kif.col !== 4'b1110) begin
      errors++; $display("FAIL reset_col: got %b want 1110", kif.col);
    end
    checks++;
    if ({kif.key_code, kif.key_valid, kif.key_held, kif.key_overrun} !== 7'd0) begin
      errors++; $display("FAIL reset_outs: got %h/%b/%b/%b want 0", kif.key_code, kif.key_valid, kif.key_held, kif.key_overrun);
    end
    rst = 1'b1;
    for (int n = 0; n < 40; n++) begin
      exp_col = ~(one << ((n / SD) % 4));
      checks++;
      if (kif.col !== exp_col) begin
        errors++; $display("FAIL scan_col: cycle %0d got %b want %b", n, kif.col, exp_col);
      end
      checks++;
      if ({kif.key_valid, kif.key_held, kif.key_overrun} !== 3'b000) begin
        errors++; $display("FAIL idle_outs: cycle %0d got %b%b%b want 000", n, kif.key_valid, kif.key_held, kif.key_overrun);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single_press();
    int b, b2;
    logic seen_valid = 1'b0;
    frame_start(b);
    keys_down[K6] = 1'b1;
    exp_q.push_back(4'h6);
    goto_cyc(b + 33);
    checks++;
    if (kif.key_valid !== 1'b0 || kif.key_held !== 1'b1) begin
      errors++; $display("FAIL press_early: valid %b held %b want 0/1", kif.key_valid, kif.key_held);
    end
    goto_cyc(b + 34);
    checks++;
    if (kif.key_valid !== 1'b1 || exp_q.size() == 0 || kif.key_code !== exp_q[0]) begin
      errors++; $display("FAIL press_valid: valid %b code %h want 1/6", kif.key_valid, kif.key_code);
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    kif.key_ack = 1'b1;
    @(negedge clk);
    kif.key_ack = 1'b0;
    checks++;
    if (kif.key_valid !== 1'b0 || kif.key_code !== 4'h6) begin
      errors++; $display("FAIL ack_clear: valid %b code %h want 0/6", kif.key_valid, kif.key_code);
    end
    b2 = b + 3 * FR;
    goto_cyc(b2);
    keys_down[K6] = 1'b0;
    goto_cyc(b2 + 32);
    checks++;
    if (kif.key_held !== 1'b1) begin
      errors++; $display("FAIL release_early: held %b want 1", kif.key_held);
    end
    goto_cyc(b2 + 33);
    checks++;
    if (kif.key_held !== 1'b0) begin
      errors++; $display("FAIL release_held: held %b want 0", kif.key_held);
    end
    for (int n = 0; n < 3 * FR; n++) begin
      if (kif.key_valid) seen_valid = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      errors++; $display("FAIL release_event: valid seen %b want 0", seen_valid);
    end
  endtask

  task automatic test_bounce();
    int b;
    logic seen_valid = 1'b0;
    logic seen_held = 1'b0;
    frame_start(b);
    for (int n = 0; n < 6 * FR + 3 * FR; n++) begin
      if (n < 6 * FR && (n % FR) == 0) keys_down[K5] = ((n / FR) % 2 == 0);
      if (n == 6 * FR) keys_down[K5] = 1'b0;
      if (kif.key_valid) seen_valid = 1'b1;
      if (kif.key_held) seen_held = 1'b1;
      @(negedge clk);
    end
    keys_down[K5] = 1'b0;
    checks++;
    if (seen_valid !== 1'b0) begin
      errors++; $display("FAIL bounce_valid: seen %b want 0", seen_valid);
    end
    checks++;
    if (seen_held !== 1'b0) begin
      errors++; $display("FAIL bounce_held: seen %b want 0", seen_held);
    end
  endtask

  task automatic test_overrun();
    int b, b3;
    frame_start(b);
    keys_down[KA] = 1'b1;
    exp_q.push_back(4'hA);
    goto_cyc(b + 34);
    checks++;
    if (kif.key_valid !== 1'b1 || exp_q.size() == 0 || kif.key_code !== exp_q[0]) begin
      errors++; $display("FAIL ovr_first: valid %b code %h want 1/a", kif.key_valid, kif.key_code);
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    goto_cyc(b + 3 * FR);
    keys_down[KA] = 1'b0;
    b3 = b + 5 * FR;
    goto_cyc(b3);
    keys_down[K3] = 1'b1;
    goto_cyc(b3 + 33);
    checks++;
    if (kif.key_overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_early: overrun %b want 0", kif.key_overrun);
    end
    goto_cyc(b3 + 34);
    checks++;
    if (kif.key_overrun !== 1'b1 || kif.key_valid !== 1'b1 || kif.key_code !== 4'hA) begin
      errors++; $display("FAIL ovr_flag: ovr %b valid %b code %h want 1/1/a", kif.key_overrun, kif.key_valid, kif.key_code);
    end
    kif.key_ack = 1'b1;
    @(negedge clk);
    kif.key_ack = 1'b0;
    checks++;
    if (kif.key_valid !== 1'b0 || kif.key_overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_ack: valid %b ovr %b want 0/0", kif.key_valid, kif.key_overrun);
    end
    goto_cyc(b3 + 3 * FR);
    keys_down[K3] = 1'b0;
    goto_cyc(b3 + 6 * FR);
  endtask

  task automatic test_same_cycle_ack();
    int b, b2;
    frame_start(b);
    keys_down[K1] = 1'b1;
    exp_q.push_back(4'h1);
    goto_cyc(b + 34);
    checks++;
    if (kif.key_valid !== 1'b1 || exp_q.size() == 0 || kif.key_code !== exp_q[0]) begin
      errors++; $display("FAIL sca_first: valid %b code %h want 1/1", kif.key_valid, kif.key_code);
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    goto_cyc(b + 3 * FR);
    keys_down[K1] = 1'b0;
    b2 = b + 5 * FR;
    goto_cyc(b2);
    keys_down[K2] = 1'b1;
    exp_q.push_back(4'h2);
    goto_cyc(b2 + 33);
    checks++;
    if (kif.key_valid !== 1'b1 || kif.key_code !== 4'h1) begin
      errors++; $display("FAIL sca_pending: valid %b code %h want 1/1", kif.key_valid, kif.key_code);
    end
    kif.key_ack = 1'b1;
    @(negedge clk);
    kif.key_ack = 1'b0;
    checks++;
    if (kif.key_valid !== 1'b1 || kif.key_overrun !== 1'b0 || exp_q.size() == 0 || kif.key_code !== exp_q[0]) begin
      errors++; $display("FAIL sca_replace: valid %b ovr %b code %h want 1/0/2", kif.key_valid, kif.key_overrun, kif.key_code);
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic test_multi_reset();
    int b;
    logic seen_valid = 1'b0;
    frame_start(b);
    keys_down = '0;
    keys_down[K1] = 1'b1;
    keys_down[K9] = 1'b1;
    goto_cyc(b + 3 * FR + 2);
    checks++;
    if (kif.key_held !== 1'b1 || kif.key_valid !== 1'b1 || kif.key_code !== 4'h2) begin
      errors++; $display("FAIL multi_invalid: held %b valid %b code %h want 1/1/2", kif.key_held, kif.key_valid, kif.key_code);
    end
    goto_cyc(b + 4 * FR + 6);
    rst = 1'b0;
    keys_down = '0;
    keys_down[K9] = 1'b1;
    #1;
    checks++;
    if (kif.col !== 4'b1110) begin
      errors++; $display("FAIL midreset_col: got %b want 1110", kif.col);
    end
    checks++;
    if ({kif.key_code, kif.key_valid, kif.key_held, kif.key_overrun} !== 7'd0) begin
      errors++; $display("FAIL midreset_outs: got %h/%b/%b/%b want 0", kif.key_code, kif.key_valid, kif.key_held, kif.key_overrun);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(4'h9);
    for (int n = 0; n < 34; n++) begin
      if (kif.key_valid) seen_valid = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_early: valid seen %b want 0", seen_valid);
    end
    checks++;
    if (cyc !== 34 || kif.key_valid !== 1'b1 || exp_q.size() == 0 || kif.key_code !== exp_q[0]) begin
      errors++; $display("FAIL post_reset_key: cyc %0d valid %b code %h want 34/1/9", cyc, kif.key_valid, kif.key_code);
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    keys_down = '0;
  endtask

  initial begin
    kif.key_ack = 1'b0;
    test_reset();
    test_single_press();
    test_bounce();
    test_overrun();
    test_same_cycle_ack();
    test_multi_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
